// File: rtl/reduceron_io_pkg.sv
// Shared constants for the Reduceron IO bridge: IO register addresses and STATUS bit layout.
package reduceron_io_pkg;

    localparam int unsigned ADDR_PUTCHAR = 0;
    localparam int unsigned ADDR_STATUS  = 1;
    localparam int unsigned ADDR_CYC_LO  = 2;
    localparam int unsigned ADDR_CYC_HI  = 3;

    localparam int STAT_FULL     = 0;
    localparam int STAT_EMPTY    = 1;
    localparam int STAT_DONE     = 2;
    localparam int STAT_OVERFLOW = 3;
    localparam int STAT_BAD_ADDR = 4;

endpackage

// File: rtl/reduceron_io_fifo.sv
// Synchronous FIFO for the putchar byte stream; a push into a full FIFO is taken only when a pop
// happens in the same cycle.
module reduceron_io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);
    // Drive zero while empty so the sink never sees stale bytes.
    assign o_head   = o_empty ? '0 : r_mem[r_rdPtr];

    always_ff @(posedge clock) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_doPush && w_doPop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/reduceron_io_bridge.sv
// IO bus terminator for the Reduceron core: putchar FIFO, STATUS/cycle registers, finish capture.
// Optional REDUCERON_IO_CYCLE_COUNT_EN enables the run-cycle counter; otherwise cycles reads 0.
module reduceron_io_bridge #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 15,
    parameter int RESULT_W   = 18,
    parameter int FIFO_DEPTH = 16,
    parameter int CYC_W      = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [RESULT_W-1:0] core_r,
    input  logic                core_finish,
    input  logic [ADDR_W-1:0]   io_addr,
    input  logic                io_write,
    input  logic                io_read,
    input  logic [DATA_W-1:0]   io_wdata,
    output logic [DATA_W-1:0]   io_rdata,
    output logic                io_rvalid,
    output logic                io_stall,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [RESULT_W-1:0] result,
    output logic                done,
    output logic [CYC_W-1:0]    cycles,
    output logic                overflow,
    output logic                bad_addr
);
    import reduceron_io_pkg::*;

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_drop;
    logic                w_unmapped;
    logic                w_capture;
    logic                w_unused;
    logic [7:0]          w_head;
    logic [DATA_W-1:0]   w_status;
    logic [DATA_W-1:0]   w_rmux;
    logic [2*DATA_W-1:0] w_cycExt;

    logic [DATA_W-1:0]   r_rdata;
    logic                r_rvalid;
    logic [RESULT_W-1:0] r_result;
    logic                r_done;
    logic                r_overflow;
    logic                r_badAddr;

    assign w_unmapped = (io_addr > ADDR_W'(ADDR_CYC_HI));
    assign w_push     = io_write && (io_addr == ADDR_W'(ADDR_PUTCHAR));
    assign w_pop      = tx_valid && tx_ready;
    assign w_drop     = w_push && w_full && !w_pop;
    assign w_capture  = core_finish && !r_done;
    assign w_unused   = ^{1'b0, io_wdata};

    reduceron_io_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (io_wdata[7:0]),
        .i_pop   (tx_ready),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

`ifdef REDUCERON_IO_CYCLE_COUNT_EN
    logic [CYC_W-1:0] r_cycles;

    // Counts every edge until done, including the capture edge, and holds at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cycles <= '0;
        end else if (!r_done && (r_cycles != '1)) begin
            r_cycles <= r_cycles + CYC_W'(1);
        end
    end

    assign cycles = r_cycles;
`else
    assign cycles = '0;
`endif

    always_comb begin
        w_cycExt = '0;
        w_cycExt[CYC_W-1:0] = cycles;
        w_status = '0;
        w_status[STAT_FULL]     = w_full;
        w_status[STAT_EMPTY]    = w_empty;
        w_status[STAT_DONE]     = r_done;
        w_status[STAT_OVERFLOW] = r_overflow;
        w_status[STAT_BAD_ADDR] = r_badAddr;
        w_rmux = '0;
        case (io_addr)
            ADDR_W'(ADDR_STATUS): w_rmux = w_status;
            ADDR_W'(ADDR_CYC_LO): w_rmux = w_cycExt[DATA_W-1:0];
            ADDR_W'(ADDR_CYC_HI): w_rmux = w_cycExt[2*DATA_W-1:DATA_W];
            default:              w_rmux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_badAddr  <= 1'b0;
        end else begin
            r_rvalid <= io_read;
            r_rdata  <= io_read ? w_rmux : '0;
            if (w_capture) begin
                r_result <= core_r;
                r_done   <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if ((io_read || io_write) && w_unmapped) begin
                r_badAddr <= 1'b1;
            end
        end
    end

    assign io_rdata  = r_rdata;
    assign io_rvalid = r_rvalid;
    assign io_stall  = w_full;
    assign tx_data   = w_head;
    assign tx_valid  = !w_empty;
    assign result    = r_result;
    assign done      = r_done;
    assign overflow  = r_overflow;
    assign bad_addr  = r_badAddr;

endmodule

// File: tb/tb_reduceron_io_bridge.sv
// Self-checking bench for reduceron_io_bridge: vector table plus hand sequences, with
// scoreboard queues for the tx byte stream and read responses.
module tb_reduceron_io_bridge;
    import reduceron_io_pkg::*;

    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 15;
    localparam int RESULT_W   = 18;
    localparam int FIFO_DEPTH = 16;
    localparam int CYC_W      = 32;

`ifdef REDUCERON_IO_CYCLE_COUNT_EN
    localparam logic [31:0] EXP_CYC = 32'd100;
`else
    localparam logic [31:0] EXP_CYC = 32'd0;
`endif

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic [RESULT_W-1:0] core_r = '0;
    logic                core_finish = 1'b0;
    logic [ADDR_W-1:0]   io_addr = '0;
    logic                io_write = 1'b0;
    logic                io_read = 1'b0;
    logic [DATA_W-1:0]   io_wdata = '0;
    logic [DATA_W-1:0]   io_rdata;
    logic                io_rvalid;
    logic                io_stall;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready = 1'b0;
    logic [RESULT_W-1:0] result;
    logic                done;
    logic [CYC_W-1:0]    cycles;
    logic                overflow;
    logic                bad_addr;

    int nChecks = 0;
    int nErrors = 0;
    logic [7:0]        txQ[$];
    logic [DATA_W-1:0] rdQ[$];

    typedef struct {
        logic              wr;
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] expRdata;
    } vec_t;
    vec_t vecs[13];

    reduceron_io_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESULT_W(RESULT_W),
        .FIFO_DEPTH(FIFO_DEPTH), .CYC_W(CYC_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .core_r(core_r), .core_finish(core_finish),
        .io_addr(io_addr), .io_write(io_write), .io_read(io_read), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_rvalid(io_rvalid), .io_stall(io_stall),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .result(result), .done(done), .cycles(cycles),
        .overflow(overflow), .bad_addr(bad_addr)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: handshakes and read responses are sampled on the falling edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (tx_valid && tx_ready) begin
                if (txQ.size() == 0) begin
                    nChecks++;
                    nErrors++;
                    $display("[TB] FAIL tx_unexpected: got byte 0x%0h, expected none", tx_data);
                end else begin
                    checkOutput("tx_data", 32'(tx_data), 32'(txQ.pop_front()));
                end
            end
            if (io_rvalid) begin
                if (rdQ.size() == 0) begin
                    nChecks++;
                    nErrors++;
                    $display("[TB] FAIL rvalid_unexpected: got 0x%0h, expected no response", io_rdata);
                end else begin
                    checkOutput("io_rdata", 32'(io_rdata), 32'(rdQ.pop_front()));
                end
            end else if (io_rdata !== '0) begin
                checkOutput("rdata_idle", 32'(io_rdata), 32'd0);
            end
        end
    end

    // Drives one bus cycle starting just after a rising edge; returns 1 time unit after the next.
    task automatic applyStimulus(input logic wr, input logic rd,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        io_write = wr;
        io_read  = rd;
        io_addr  = addr;
        io_wdata = wdata;
        @(posedge clock);
        #1;
        io_write = 1'b0;
        io_read  = 1'b0;
    endtask

    task automatic putByte(input logic [7:0] b, input bit accepted);
        if (accepted) txQ.push_back(b);
        applyStimulus(1'b1, 1'b0, ADDR_W'(ADDR_PUTCHAR), DATA_W'(b));
    endtask

    task automatic readReg(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
        rdQ.push_back(exp);
        applyStimulus(1'b0, 1'b1, addr, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        checkOutput({tag, "_tx_data"},  32'(tx_data),  32'd0);
        checkOutput({tag, "_done"},     32'(done),     32'd0);
        checkOutput({tag, "_result"},   32'(result),   32'd0);
        checkOutput({tag, "_cycles"},   32'(cycles),   32'd0);
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
        checkOutput({tag, "_bad_addr"}, 32'(bad_addr), 32'd0);
        checkOutput({tag, "_io_stall"}, 32'(io_stall), 32'd0);
        checkOutput({tag, "_rvalid"},   32'(io_rvalid), 32'd0);
    endtask

    task automatic resetDut();
        io_write = 1'b0;
        io_read = 1'b0;
        core_finish = 1'b0;
        tx_ready = 1'b0;
        reset_n = 1'b0;
        txQ.delete();
        rdQ.delete();
        repeat (2) @(posedge clock);
        #1;
        checkResetState("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string tag);
        tx_ready = 1'b1;
        for (int k = 0; k < 60 && txQ.size() != 0; k++) idle(1);
        idle(1);
        checkOutput({tag, "_drained"}, 32'(txQ.size()), 32'd0);
        checkOutput({tag, "_tx_valid_after"}, 32'(tx_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 15'd1,      15'd0,     15'h02};
        vecs[1]  = '{1'b0, 1'b1, 15'd0,      15'd0,     15'h00};
        vecs[2]  = '{1'b1, 1'b0, 15'd2,      15'd7,     15'h00};
        vecs[3]  = '{1'b0, 1'b1, 15'd1,      15'd0,     15'h02};
        vecs[4]  = '{1'b1, 1'b0, 15'd0,      15'h041,   15'h00};
        vecs[5]  = '{1'b1, 1'b0, 15'd0,      15'h142,   15'h00};
        vecs[6]  = '{1'b1, 1'b1, 15'd0,      15'h043,   15'h00};
        vecs[7]  = '{1'b0, 1'b1, 15'd1,      15'd0,     15'h00};
        vecs[8]  = '{1'b0, 1'b1, 15'd1,      15'd0,     15'h02};
        vecs[9]  = '{1'b0, 1'b1, 15'h7FFF,   15'd0,     15'h00};
        vecs[10] = '{1'b0, 1'b1, 15'd1,      15'd0,     15'h12};
        vecs[11] = '{1'b0, 1'b1, 15'd3,      15'd0,     15'h00};
        vecs[12] = '{1'b1, 1'b1, 15'h0100,   15'h055,   15'h00};

        // Finish capture at the 100th edge after reset release.
        resetDut();
        core_r = 18'h2A5A5;
        repeat (98) @(posedge clock);
        #1;
        core_finish = 1'b1;
        @(posedge clock);
        #1;
        core_finish = 1'b0;
        checkOutput("finish_done", 32'(done), 32'd1);
        checkOutput("finish_result", 32'(result), 32'h2A5A5);
        checkOutput("finish_cycles", 32'(cycles), EXP_CYC);
        readReg(ADDR_W'(ADDR_CYC_LO), DATA_W'(EXP_CYC));
        readReg(ADDR_W'(ADDR_CYC_HI), '0);
        readReg(ADDR_W'(ADDR_STATUS), DATA_W'(6));
        core_r = 18'h00001;
        core_finish = 1'b1;
        idle(3);
        core_finish = 1'b0;
        idle(1);
        checkOutput("refinish_result", 32'(result), 32'h2A5A5);
        checkOutput("refinish_cycles", 32'(cycles), EXP_CYC);
        checkOutput("refinish_done", 32'(done), 32'd1);
        checkOutput("bad_addr_clean", 32'(bad_addr), 32'd0);

        // Vector table with the sink always ready.
        resetDut();
        tx_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr && vecs[i].addr == ADDR_W'(ADDR_PUTCHAR)) txQ.push_back(vecs[i].wdata[7:0]);
            if (vecs[i].rd) rdQ.push_back(vecs[i].expRdata);
            applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
        end
        idle(3);
        checkOutput("table_tx_drained", 32'(txQ.size()), 32'd0);
        checkOutput("table_bad_addr", 32'(bad_addr), 32'd1);
        checkOutput("table_overflow", 32'(overflow), 32'd0);

        // "Hi" stream: tx_valid rises the cycle after the first push.
        resetDut();
        tx_ready = 1'b1;
        putByte(8'h48, 1'b1);
        checkOutput("hi_tx_valid_rise", 32'(tx_valid), 32'd1);
        putByte(8'h69, 1'b1);
        drain("hi");

        // Fill with sink stalled, then overflow on the 17th write.
        resetDut();
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            putByte(8'(8'h10 + i), 1'b1);
            if (i == FIFO_DEPTH - 2) checkOutput("stall_before_full", 32'(io_stall), 32'd0);
        end
        checkOutput("stall_full", 32'(io_stall), 32'd1);
        checkOutput("overflow_before_drop", 32'(overflow), 32'd0);
        putByte(8'hEE, 1'b0);
        checkOutput("overflow_set", 32'(overflow), 32'd1);
        checkOutput("head_stable", 32'(tx_data), 32'h10);
        checkOutput("head_valid", 32'(tx_valid), 32'd1);
        readReg(ADDR_W'(ADDR_STATUS), DATA_W'(9));
        drain("ovf");

        // Full FIFO with a simultaneous pop accepts the new byte.
        resetDut();
        for (int i = 0; i < FIFO_DEPTH; i++) putByte(8'(8'h20 + i), 1'b1);
        tx_ready = 1'b1;
        putByte(8'h77, 1'b1);
        tx_ready = 1'b0;
        idle(1);
        checkOutput("pushpop_overflow", 32'(overflow), 32'd0);
        checkOutput("pushpop_still_full", 32'(io_stall), 32'd1);
        checkOutput("pushpop_head", 32'(tx_data), 32'h21);
        drain("pushpop");

        // Asynchronous reset in the middle of a drain.
        resetDut();
        core_r = 18'h00055;
        core_finish = 1'b1;
        idle(1);
        core_finish = 1'b0;
        applyStimulus(1'b1, 1'b0, ADDR_W'(4), DATA_W'(8'h99));
        for (int i = 0; i < 5; i++) putByte(8'(8'hA0 + i), 1'b1);
        tx_ready = 1'b1;
        idle(1);
        checkOutput("middrain_done", 32'(done), 32'd1);
        checkOutput("middrain_bad_addr", 32'(bad_addr), 32'd1);
        checkOutput("middrain_tx_valid", 32'(tx_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        txQ.delete();
        rdQ.delete();
        checkResetState("async");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("post_reset_tx_valid", 32'(tx_valid), 32'd0);

        idle(2);
        checkOutput("reads_all_answered", 32'(rdQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
